// File: rtl/sn2bin_pkg.sv
// Shared definitions for the stochastic-to-binary accumulator.
// Holds the default widths and the FSM state encoding used by sn2bin_acc.
package sn2bin_pkg;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int WIN_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    COUNT = ST_COUNT,
    HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/sn2bin_acc_if.sv
// Bus between the stochastic source / result consumer and sn2bin_acc.
//   start, win_len      : conversion request and window length (0 = 2^WIN_WIDTH)
//   sn_in, sn_valid     : stochastic bit and its qualifier
//   busy, bin_out, sat  : status and result
//   bin_valid, bin_ready: result handshake
// master = environment side, slave = converter side.
interface sn2bin_acc_if
  import sn2bin_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int WIN_WIDTH = WIN_WIDTH_DEF
) ();

  logic                 start;
  logic [WIN_WIDTH-1:0] win_len;
  logic                 sn_in;
  logic                 sn_valid;
  logic                 busy;
  logic [CNT_WIDTH-1:0] bin_out;
  logic                 bin_valid;
  logic                 bin_ready;
  logic                 sat;

  modport master (
    output start, win_len, sn_in, sn_valid, bin_ready,
    input  busy, bin_out, bin_valid, sat
  );

  modport slave (
    input  start, win_len, sn_in, sn_valid, bin_ready,
    output busy, bin_out, bin_valid, sat
  );

endinterface

// File: rtl/sn2bin_win_ctr.sv
// Window down-counter for sn2bin_acc.
// One bit wider than win_len so a full 2^WIN_WIDTH window fits.
// Ports: clk, rst (async, active-high), load/load_val (reload),
//        dec (decrement enable), last (count == 1, combinational).
module sn2bin_win_ctr
  import sn2bin_pkg::*;
#(
  parameter int WIN_WIDTH = WIN_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIN_WIDTH:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [WIN_WIDTH:0] count;

  // Load takes priority over decrement; the counter never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - (WIN_WIDTH + 1)'(1);
    end else begin
      count <= count;
    end
  end

  assign last = (count == (WIN_WIDTH + 1)'(1));

endmodule

// File: rtl/sn2bin_acc.sv
// Stochastic-to-binary converter: counts ones of a serial stochastic
// bitstream over a window of valid samples, then presents the saturating
// count with a valid/ready handshake.
// Ports: clk, rst (async, active-high), bus (sn2bin_acc_if.slave) carrying
//        start/win_len, sn_in/sn_valid, busy, bin_out/bin_valid/bin_ready, sat.
module sn2bin_acc
  import sn2bin_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int WIN_WIDTH = WIN_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  sn2bin_acc_if.slave  bus
);

  state_t               state;
  logic [CNT_WIDTH-1:0] ones;
  logic [CNT_WIDTH-1:0] ones_next;
  logic [CNT_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 busy_reg;
  logic                 sat_flag;

  logic                 handshake;
  logic                 start_acc;
  logic                 sample;
  logic                 inc;
  logic                 at_max;
  logic                 last;
  logic [WIN_WIDTH:0]   load_val;

  // In HOLD bin_valid is always high, so bin_ready alone completes the transfer.
  assign handshake = (state == HOLD) && bus.bin_ready;
  assign start_acc = bus.start && ((state == IDLE) || handshake);
  assign sample    = (state == COUNT) && bus.sn_valid;
  assign inc       = sample && bus.sn_in;
  assign at_max    = (ones == {CNT_WIDTH{1'b1}});

  // A zero window length selects the full 2^WIN_WIDTH window.
  always_comb begin
    load_val = '0;
    if (bus.win_len == '0) begin
      load_val = {1'b1, {WIN_WIDTH{1'b0}}};
    end else begin
      load_val = {1'b0, bus.win_len};
    end
  end

  // Saturating ones count including the current sample.
  always_comb begin
    ones_next = ones;
    if (inc && !at_max) begin
      ones_next = ones + CNT_WIDTH'(1);
    end else begin
      ones_next = ones;
    end
  end

  sn2bin_win_ctr #(
    .WIN_WIDTH (WIN_WIDTH)
  ) u_win_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc),
    .load_val (load_val),
    .dec      (sample),
    .last     (last)
  );

  // Conversion FSM with the ones counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ones         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy_reg     <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= COUNT;
            ones     <= '0;
            sat_flag <= 1'b0;
            busy_reg <= 1'b1;
          end
        end
        COUNT: begin
          if (sample) begin
            ones <= ones_next;
            // sat is sticky: an increment attempted at full scale is lost.
            if (inc && at_max) begin
              sat_flag <= 1'b1;
            end
            if (last) begin
              result       <= ones_next;
              result_valid <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.bin_ready) begin
            result_valid <= 1'b0;
            // Back-to-back start keeps busy high and skips IDLE.
            if (bus.start) begin
              state    <= COUNT;
              ones     <= '0;
              sat_flag <= 1'b0;
            end else begin
              state    <= IDLE;
              busy_reg <= 1'b0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.bin_out   = result;
  assign bus.bin_valid = result_valid;
  assign bus.sat       = sat_flag;

endmodule

// File: tb/tb_sn2bin_acc.sv
// Self-checking bench for sn2bin_acc. The reference is a plain count of the
// ones seen on valid cycles, clamped to the counter range.
module tb_sn2bin_acc;

  localparam int CW   = 8;
  localparam int WW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sn2bin_acc_if #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) bus ();

  sn2bin_acc #(.CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_out = 0;
  bit exp_sat = 1'b0;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.bin_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.bin_valid); end
    total++; if (bus.bin_out !== '0) begin bad++; $display("FAIL reset_out got=%0d want=0", bus.bin_out); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b want=0", bus.sat); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", bus.busy); end
  endtask

  // Request a conversion from IDLE; returns at the negedge after acceptance.
  task automatic start_conv(input int w);
    bus.start   = 1'b1;
    bus.win_len = WW'(w);
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", bus.busy); end
  endtask

  // Feed samples until the window closes; vmode: 0 always valid, 1 pattern
  // 1,0,0, else random. imode: 0 ones, 1 alternating, 2 random, else 5-of-16.
  task automatic feed_window(input int w, input int vmode, input int imode, input bit junk);
    int n;
    int cnt;
    int ones;
    int cyc;
    n = (w == 0) ? (1 << WW) : w;
    cnt = 0; ones = 0; cyc = 0;
    while (cnt < n && cyc < 4 * n + 50) begin
      bit v;
      bit b;
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      if (v) begin
        case (imode)
          0:       b = 1'b1;
          1:       b = (cnt % 2 == 0);
          2:       b = 1'($urandom_range(0, 1));
          default: b = (cnt % 16 < 5);
        endcase
      end else begin
        b = 1'b1;
      end
      bus.sn_valid = v;
      bus.sn_in    = b;
      if (junk) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.win_len = WW'($urandom);
      end
      @(negedge clk);
      cyc++;
      if (v) begin
        cnt++;
        ones += int'(b);
      end
      total++;
      if (bus.bin_valid !== (cnt == n)) begin
        bad++;
        $display("FAIL window_valid cyc=%0d samples=%0d/%0d got=%0b want=%0b", cyc, cnt, n, bus.bin_valid, (cnt == n));
      end
    end
    bus.sn_valid = 1'b0;
    bus.sn_in    = 1'b0;
    bus.start    = 1'b0;
    total++; if (cnt < n) begin bad++; $display("FAIL window_timeout got=%0d want=%0d samples", cnt, n); end
    exp_out = (ones > MAXC) ? MAXC : ones;
    exp_sat = (ones > MAXC);
    total++; if (bus.bin_out !== CW'(exp_out)) begin bad++; $display("FAIL result_out got=%0d want=%0d", bus.bin_out, exp_out); end
    total++; if (bus.sat !== exp_sat) begin bad++; $display("FAIL result_sat got=%0b want=%0b", bus.sat, exp_sat); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL result_busy got=%0b want=1", bus.busy); end
  endtask

  // Stall the consumer hold_n cycles, then accept (optionally restarting).
  task automatic handshake(input int hold_n, input bit do_start, input int next_w);
    for (int k = 0; k < hold_n; k++) begin
      bus.bin_ready = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      bus.win_len   = WW'($urandom);
      bus.sn_valid  = 1'b1;
      bus.sn_in     = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++; if (bus.bin_valid !== 1'b1) begin bad++; $display("FAIL hold_valid k=%0d got=%0b want=1", k, bus.bin_valid); end
      total++; if (bus.bin_out !== CW'(exp_out)) begin bad++; $display("FAIL hold_out k=%0d got=%0d want=%0d", k, bus.bin_out, exp_out); end
      total++; if (bus.sat !== exp_sat) begin bad++; $display("FAIL hold_sat k=%0d got=%0b want=%0b", k, bus.sat, exp_sat); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL hold_busy k=%0d got=%0b want=1", k, bus.busy); end
    end
    bus.bin_ready = 1'b1;
    bus.start     = do_start;
    bus.win_len   = WW'(next_w);
    bus.sn_valid  = 1'b0;
    bus.sn_in     = 1'b0;
    @(negedge clk);
    bus.bin_ready = 1'b0;
    bus.start     = 1'b0;
    total++; if (bus.bin_valid !== 1'b0) begin bad++; $display("FAIL xfer_valid got=%0b want=0", bus.bin_valid); end
    total++; if (bus.busy !== do_start) begin bad++; $display("FAIL xfer_busy got=%0b want=%0b", bus.busy, do_start); end
    total++; if (bus.bin_out !== CW'(exp_out)) begin bad++; $display("FAIL xfer_out got=%0d want=%0d", bus.bin_out, exp_out); end
    total++; if (bus.sat !== (do_start ? 1'b0 : exp_sat)) begin bad++; $display("FAIL xfer_sat got=%0b want=%0b", bus.sat, (do_start ? 1'b0 : exp_sat)); end
  endtask

  task automatic test_prg_pattern();
    start_conv(16);
    feed_window(16, 0, 3, 1'b0);
    total++; if (bus.bin_out !== 8'd5) begin bad++; $display("FAIL prg_out got=%0d want=5", bus.bin_out); end
    handshake(2, 1'b0, 0);
  endtask

  task automatic test_saturation();
    start_conv(0);
    feed_window(0, 0, 0, 1'b0);
    total++; if (bus.bin_out !== 8'd255 || bus.sat !== 1'b1) begin bad++; $display("FAIL sat_full got=%0d/%0b want=255/1", bus.bin_out, bus.sat); end
    handshake(3, 1'b1, 8);
    feed_window(8, 0, 1, 1'b0);
    total++; if (bus.bin_out !== 8'd4 || bus.sat !== 1'b0) begin bad++; $display("FAIL sat_clear got=%0d/%0b want=4/0", bus.bin_out, bus.sat); end
    handshake(0, 1'b0, 0);
  endtask

  task automatic test_stall();
    start_conv(8);
    feed_window(8, 1, 0, 1'b0);
    total++; if (bus.bin_out !== 8'd8) begin bad++; $display("FAIL stall_out got=%0d want=8", bus.bin_out); end
    handshake(1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    start_conv(35);
    feed_window(35, 0, 0, 1'b1);
    total++; if (bus.bin_out !== 8'h23) begin bad++; $display("FAIL b2b_out got=%0d want=35", bus.bin_out); end
    handshake(10, 1'b1, 12);
    feed_window(12, 2, 2, 1'b0);
    handshake(0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    start_conv(16);
    bus.sn_valid = 1'b1;
    bus.sn_in    = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.bin_valid !== 1'b0 || bus.bin_out !== '0 || bus.sat !== 1'b0) begin
      bad++; $display("FAIL rst_count got=%0b/%0b/%0d/%0b want=0/0/0/0", bus.busy, bus.bin_valid, bus.bin_out, bus.sat);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.sn_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%0b want=0", bus.busy); end
    start_conv(4);
    feed_window(4, 0, 0, 1'b0);
    total++; if (bus.bin_out !== 8'd4) begin bad++; $display("FAIL rst_fresh got=%0d want=4", bus.bin_out); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.bin_valid !== 1'b0 || bus.bin_out !== '0 || bus.sat !== 1'b0) begin
      bad++; $display("FAIL rst_hold got=%0b/%0b/%0d/%0b want=0/0/0/0", bus.busy, bus.bin_valid, bus.bin_out, bus.sat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_conv(4);
    feed_window(4, 0, 2, 1'b0);
    handshake(0, 1'b0, 0);
  endtask

  task automatic test_random();
    bit in_hold;
    int w;
    in_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      w = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 40);
      if (!in_hold) begin
        start_conv(w);
      end else begin
        handshake($urandom_range(0, 4), 1'b1, w);
      end
      feed_window(w, 2, 2, 1'b1);
      in_hold = 1'b1;
    end
    handshake(1, 1'b0, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.win_len   = '0;
    bus.sn_in     = 1'b0;
    bus.sn_valid  = 1'b0;
    bus.bin_ready = 1'b0;
    #1;
    test_reset();
    test_prg_pattern();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/sn2bin_acc.md
Name: sn2bin_acc

Overview:
Stochastic-to-binary converter. It sits directly downstream of the DSC MAC adder output (det_stoch_scale_add y).
- Counts ones in a serial stochastic bitstream over a programmable window of valid samples.
- Registers the result and presents it with a valid/ready handshake.
- Replaces the free-running enable-gated counter, adding framing, stall support, saturation and result hold.

Parameters:
- CNT_WIDTH, 8, width of ones count and bin_out.
- WIN_WIDTH, 8, width of win_len and the internal window down-counter; max window 2^WIN_WIDTH samples.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request new conversion; accepted only in IDLE or on the HOLD handshake cycle.
- win_len  in  WIN_WIDTH  window length in valid samples, sampled on start acceptance; 0 means 2^WIN_WIDTH.
- sn_in  in  1  stochastic bit from the upstream adder.
- sn_valid  in  1  sn_in qualifier; 0 stalls the window.
- busy  out  1  high in COUNT and HOLD.
- bin_out  out  CNT_WIDTH  ones count of the last completed window.
- bin_valid  out  1  result valid, high only in HOLD.
- bin_ready  in  1  consumer accepts result.
- sat  out  1  count saturated during the current/held window.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, bin_valid=0, bin_out=0, sat=0, window counter=0, ones counter=0. Reset mid-COUNT or mid-HOLD discards all partial and held results.
- States: IDLE, COUNT, HOLD. Encoding comes from a package constant.
- IDLE:
  - start=1: latch win_len (0 -> 2^WIN_WIDTH) into the window counter, clear ones counter and sat, go to COUNT.
  - The start-cycle sn_in is NOT sampled; the first sample is taken the cycle after start.
- COUNT, per cycle with sn_valid=1:
  - Window counter decrements.
  - If sn_in=1, ones counter increments, saturating at 2^CNT_WIDTH-1. An increment attempted at max sets sat=1 (sticky until the next start).
  - sn_valid=0: no change to either counter.
  - Last sample (window counter==1 and sn_valid=1): next cycle bin_out=final count including that sample, bin_valid=1, state=HOLD. Latency from last sample to bin_valid is 1 cycle.
  - start during COUNT is ignored; win_len changes after acceptance have no effect.
- HOLD:
  - bin_out, sat and bin_valid are held stable while bin_ready=0, indefinitely.
  - bin_valid & bin_ready: transfer completes; next cycle bin_valid=0.
  - If start=1 in the same cycle, go directly to COUNT (back-to-back, no IDLE bubble) with new win_len; otherwise go to IDLE.
  - bin_out retains its value after transfer until the next result is loaded. sn_in is ignored in HOLD and IDLE.
- busy: 1 from the cycle after start acceptance through the handshake cycle. It stays 1 continuously for back-to-back conversions.
- Arithmetic:
  - Unsigned.
  - Window counter is WIN_WIDTH+1 bits wide internally to hold 2^WIN_WIDTH.
  - For CNT_WIDTH >= WIN_WIDTH+1, saturation cannot occur for any window.

Decomposition:
- Package sn2bin_pkg holds the state encoding localparams (ST_IDLE=2'd0, ST_COUNT=2'd1, ST_HOLD=2'd2) and the default widths.
- One sub-module, sn2bin_win_ctr, is natural:
  - Loadable WIN_WIDTH+1 down-counter with decrement enable and a combinational "last" flag (count==1).
  - Reset is async, active-high, on clk/rst.
- FSM, ones counter and output register stay in sn2bin_acc.

Test Plan:
- prg_4b with bin_in=5 driving sn_in, sn_valid=1, start with win_len=16 -> bin_valid 1 cycle after 16th sample, bin_out=5, sat=0.
- CNT_WIDTH=4, win_len=20, sn_in=1 constant -> bin_out=15, sat=1; next start with win_len=8, sn_in alternating 1/0 -> bin_out=4, sat=0.
- win_len=8 with sn_valid toggling 1,0,0,1,... and sn_in=1 on valid cycles only -> completes after exactly 8 valid samples, bin_out=8; invalid-cycle sn_in=1 not counted.
- Result 0x23 with bin_ready=0 for 10 cycles, then start asserted alongside bin_ready=1 -> bin_out/bin_valid stable for 10 cycles; busy stays 1; new window begins next cycle; bin_valid drops.
- win_len=0, sn_in=1 for 256 samples, CNT_WIDTH=9 -> bin_out=256, sat=0; with CNT_WIDTH=8 -> bin_out=255, sat=1.
- rst pulse mid-COUNT (after 5 of 16 samples) and mid-HOLD -> outputs 0, busy=0 immediately; next start with win_len=4, sn_in=1 -> bin_out=4, no residue.
